// File: rtl/rv_pkg.sv
// Shared RV32 execute-stage definitions: M-extension funct3 codes, EX control
// word layout and the multiply/divide sequencer states.
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int CW_W  = 14;
  localparam int CNT_W = 6;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // {branch_taken,rf_wb,mem_we,wb_src[1:0],pc_src,rd[4:0],funct3[2:0]}
  localparam int CW_FUNCT3_LSB = 0;
  localparam int CW_RD_LSB     = 3;
  localparam int CW_PC_SRC_BIT = 8;
  localparam int CW_WB_SRC_LSB = 9;
  localparam int CW_MEM_WE_BIT = 11;
  localparam int CW_RF_WB_BIT  = 12;
  localparam int CW_BRANCH_BIT = 13;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_DONE
  } md_state_e;

endpackage

// File: rtl/muldiv_sign_prep.sv
// Converts RV32M operands to unsigned magnitudes and derives the sign
// corrections to apply to the final product, quotient and remainder.
module muldiv_sign_prep
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] a_mag,
  output logic [XLEN-1:0] b_mag,
  output logic            res_neg,
  output logic            rem_neg
);

  logic a_signed;
  logic b_signed;
  logic a_neg;
  logic b_neg;

  always_comb begin
    a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg    = a_signed & op_a[XLEN-1];
    b_neg    = b_signed & op_b[XLEN-1];
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    a_mag    = a_neg ? ('0 - op_a) : op_a;
    b_mag    = b_neg ? ('0 - op_b) : op_b;
    res_neg  = a_neg ^ b_neg;
    rem_neg  = a_neg;
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage: one result bit
// per cycle, pipeline held via stall_req, result presented for one cycle.
module ex_muldiv_unit
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CW_W  = 14,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [CW_W-1:0] control_word_in,
  output logic            stall_req,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [CW_W-1:0] control_word_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  md_state_e         state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   opnd_reg;
  logic [2:0]        funct3_reg;
  logic              res_neg_reg;
  logic              rem_neg_reg;
  logic [CW_W-1:0]   cw_hold_reg;
  logic [CW_W-1:0]   cw_out_reg;
  logic [XLEN-1:0]   result_reg;
  logic              result_valid_reg;

  logic [XLEN-1:0]   a_mag, b_mag;
  logic              res_neg, rem_neg;
  logic              accept, finish;
  logic              is_div_op, div_signed, fast_zero, fast_ovf, fast_path;
  logic [XLEN-1:0]   fast_value;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_step, div_step, step_next, mul_full;
  logic [XLEN-1:0]   quot, rem, final_value;

  muldiv_sign_prep #(.XLEN(XLEN)) u_sign_prep (
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .res_neg (res_neg),
    .rem_neg (rem_neg)
  );

  // Divide-by-zero and signed overflow resolve at accept without iterating.
  always_comb begin
    is_div_op  = funct3[2];
    div_signed = (funct3 == F3_DIV) || (funct3 == F3_REM);
    fast_zero  = is_div_op && (op_b == '0);
    fast_ovf   = is_div_op && div_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    fast_path  = fast_zero || fast_ovf;
    if (!funct3[1]) begin
      fast_value = fast_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
    end else begin
      fast_value = fast_zero ? op_a : '0;
    end
  end

  // acc_reg holds {product_hi, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_step  = {mul_sum, acc_reg[XLEN-1:1]};
    div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    if (div_diff[XLEN]) begin
      div_step = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
    end else begin
      div_step = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    end
    step_next = (state_reg == MD_MUL) ? mul_step : div_step;
  end

  // Result is formed from the last iteration's combinational step so DONE follows directly.
  always_comb begin
    mul_full = res_neg_reg ? ('0 - step_next) : step_next;
    quot     = step_next[XLEN-1:0];
    rem      = step_next[2*XLEN-1:XLEN];
    case (funct3_reg)
      F3_MUL:           final_value = mul_full[XLEN-1:0];
      F3_DIV, F3_DIVU:  final_value = res_neg_reg ? ('0 - quot) : quot;
      F3_REM, F3_REMU:  final_value = rem_neg_reg ? ('0 - rem) : rem;
      default:          final_value = mul_full[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= MD_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stall_req  = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      MD_IDLE: begin
        if (start && !flush) begin
          stall_req = 1'b1;
          accept    = 1'b1;
          if (fast_path) begin
            state_next = MD_DONE;
          end else begin
            state_next = is_div_op ? MD_DIV : MD_MUL;
          end
        end
      end
      MD_MUL, MD_DIV: begin
        stall_req = 1'b1;
        if (flush) begin
          state_next = MD_IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = MD_DONE;
          finish     = 1'b1;
        end
      end
      default: begin
        state_next = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg          <= '0;
      acc_reg          <= '0;
      opnd_reg         <= '0;
      funct3_reg       <= '0;
      res_neg_reg      <= 1'b0;
      rem_neg_reg      <= 1'b0;
      cw_hold_reg      <= '0;
      cw_out_reg       <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
    end else begin
      result_valid_reg <= 1'b0;
      if (accept) begin
        cnt_reg     <= '0;
        acc_reg     <= {{XLEN{1'b0}}, a_mag};
        opnd_reg    <= b_mag;
        funct3_reg  <= funct3;
        res_neg_reg <= res_neg;
        rem_neg_reg <= rem_neg;
        cw_hold_reg <= control_word_in;
        if (fast_path) begin
          result_reg       <= fast_value;
          cw_out_reg       <= control_word_in;
          result_valid_reg <= 1'b1;
        end
      end else if ((state_reg == MD_MUL || state_reg == MD_DIV) && !flush) begin
        acc_reg <= step_next;
        if (finish) begin
          result_reg       <= final_value;
          cw_out_reg       <= cw_hold_reg;
          result_valid_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign result_valid     = result_valid_reg;
  assign result           = result_reg;
  assign control_word_out = cw_out_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: arithmetic reference model plus a
// per-cycle compare of stall_req, result_valid, result and control_word_out.
module tb_ex_muldiv_unit;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [13:0] cw_in;
  logic        stall_req;
  logic        result_valid;
  logic [31:0] result;
  logic [13:0] cw_out;

  ex_muldiv_unit dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .flush            (flush),
    .funct3           (funct3),
    .op_a             (op_a),
    .op_b             (op_b),
    .control_word_in  (cw_in),
    .stall_req        (stall_req),
    .result_valid     (result_valid),
    .result           (result),
    .control_word_out (cw_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Expectation window maintained by the stimulus tasks.
  int          stall_lo  = 1;
  int          stall_hi  = 0;
  int          valid_cyc = -1;
  int          zero_cyc  = -1;
  logic [31:0] exp_result = '0;
  logic [13:0] exp_cw     = '0;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  always @(negedge clk) begin
    n_tests++;
    if (stall_req !== (cyc >= stall_lo && cyc <= stall_hi)) begin
      n_fail++;
      $display("FAIL stall_req cyc=%0d got=%b want=%b", cyc, stall_req, (cyc >= stall_lo && cyc <= stall_hi));
    end
    n_tests++;
    if (result_valid !== (cyc == valid_cyc)) begin
      n_fail++;
      $display("FAIL result_valid cyc=%0d got=%b want=%b", cyc, result_valid, (cyc == valid_cyc));
    end
    if (cyc == valid_cyc) begin
      n_tests++;
      if (result !== exp_result) begin
        n_fail++;
        $display("FAIL result cyc=%0d got=%h want=%h", cyc, result, exp_result);
      end
      n_tests++;
      if (cw_out !== exp_cw) begin
        n_fail++;
        $display("FAIL control_word_out cyc=%0d got=%h want=%h", cyc, cw_out, exp_cw);
      end
      $display("[TB] cyc=%0d result=%h cw=%h", cyc, result, cw_out);
    end
    if (cyc == zero_cyc) begin
      n_tests++;
      if (result !== 32'h0 || cw_out !== 14'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got result=%h cw=%h want 0/0", cyc, result, cw_out);
      end
    end
  end

  task automatic accept_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [13:0] cw, input logic [31:0] lit, output int t, output int lat);
    logic [31:0] m;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; start = 1'b1;
    funct3 = f; op_a = a; op_b = b; cw_in = cw;
    t   = cyc;
    m   = model(f, a, b);
    lat = is_fast(f, a, b) ? 1 : 33;
    n_tests++;
    if (m !== lit) begin
      n_fail++;
      $display("FAIL model f3=%0d a=%h b=%h got=%h want=%h", f, a, b, m, lit);
    end
    stall_lo = t; stall_hi = t + lat - 1; valid_cyc = t + lat;
    exp_result = lit; exp_cw = cw;
  endtask

  // start stays high through DONE, where it must be ignored.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [13:0] cw, input logic [31:0] lit);
    int t, lat;
    accept_op(f, a, b, cw, lit, t, lat);
    repeat (lat) @(posedge clk);
  endtask

  task automatic run_flushed(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [13:0] cw, input logic [31:0] lit);
    int t, lat;
    accept_op(f, a, b, cw, lit, t, lat);
    repeat (10) @(posedge clk); #1;
    flush = 1'b1;
    stall_hi = cyc; valid_cyc = -1;
  endtask

  task automatic run_reset(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [13:0] cw, input logic [31:0] lit);
    int t, lat;
    accept_op(f, a, b, cw, lit, t, lat);
    repeat (5) @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    stall_hi = cyc; valid_cyc = -1; zero_cyc = cyc + 1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; cw_in = '0;
    zero_cyc = 2;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;

    run_op(F3_MUL,    32'd7,          32'hFFFF_FFFD, 14'h1235, 32'hFFFF_FFEB);
    run_op(F3_MULH,   32'h8000_0000,  32'h8000_0000, 14'h2A5C, 32'h4000_0000);
    run_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 14'h0F0F, 32'hFFFF_FFFE);
    run_op(F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         14'h3001, 32'hFFFF_FFFF);
    run_op(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 14'h0777, 32'h0000_0000);
    run_op(F3_DIV,    32'hFFFF_FFF9,  32'd2,         14'h1111, 32'hFFFF_FFFD);
    run_op(F3_REM,    32'hFFFF_FFF9,  32'd2,         14'h2222, 32'hFFFF_FFFF);
    run_op(F3_REMU,   32'd100,        32'd7,         14'h0333, 32'd2);
    run_op(F3_DIVU,   32'hFFFF_FFFF,  32'd3,         14'h1444, 32'h5555_5555);
    run_op(F3_REM,    32'd7,          32'hFFFF_FFFE, 14'h3555, 32'd1);
    run_op(F3_DIV,    32'h8000_0000,  32'd1,         14'h2666, 32'h8000_0000);
    run_op(F3_DIVU,   32'd5,          32'd0,         14'h0ABC, 32'hFFFF_FFFF);
    run_op(F3_REM,    32'd5,          32'd0,         14'h1DEF, 32'd5);
    run_op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 14'h3C3C, 32'h8000_0000);
    run_op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 14'h0C3C, 32'h0);

    run_flushed(F3_DIV, 32'd100, 32'd7, 14'h1F1F, 32'd14);
    run_op(F3_MUL,    32'd3,          32'd5,         14'h2E2E, 32'd15);

    run_op(F3_DIVU,   32'd1000,       32'd10,        14'h0101, 32'd100);
    run_op(F3_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 14'h3FFE, 32'd1);
    run_reset(F3_DIV, 32'd50,         32'd3,         14'h1357, 32'd16);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
